frame_sequencer: RTL

//  Top-level frame scheduler for the raster pipeline, using a double-buffered framebuffer.
//  Per frame: clears the back buffer to clear_color, then starts the triangle rasterizer, then waits
//  for it to finish, then swaps buffers on the next vsync. Owns the single framebuffer write port.

---
 rtl/frame_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Frame scheduler for a double-buffered framebuffer: clear back buffer, run the rasterizer,
// swap on vsync. Owns the framebuffer write port and arbitrates it between clear and raster.
//
// state        | meaning
// S_IDLE       | parked; waits for enable to start a frame
// S_CLEAR      | writing clear colour to every back-buffer entry, one per cycle
// S_START      | one-cycle raster_start pulse (skipped when triangle count is zero)
// S_RENDER     | rasterizer owns the write port until raster_done
// S_WAIT_VSYNC | frame complete; swap buffers on the next vsync pulse
module frame_sequencer #(
    parameter int DISPLAY_WIDTH  = 100,
    parameter int DISPLAY_HEIGHT = 100,
    parameter int FB_DATA_BITS   = 16,
    parameter int FB_SIZE        = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int FB_ADDR_BITS   = $clog2(FB_SIZE),
    parameter int TRI_CNT_BITS   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic                    i_vsync_pulse,
    input  logic [TRI_CNT_BITS-1:0] i_tri_count,
    input  logic [FB_DATA_BITS-1:0] i_clear_color,
    output logic                    o_raster_start,
    output logic [TRI_CNT_BITS-1:0] o_raster_tri_cnt,
    input  logic                    i_raster_done,
    input  logic                    i_raster_wr_en,
    input  logic [FB_ADDR_BITS-1:0] i_raster_wr_addr,
    input  logic [FB_DATA_BITS-1:0] i_raster_wr_data,
    output logic                    o_fb_wr_en,
    output logic [FB_ADDR_BITS:0]   o_fb_wr_addr,
    output logic [FB_DATA_BITS-1:0] o_fb_wr_data,
    output logic                    o_display_buf,
    output logic                    o_busy,
    output logic                    o_frame_dropped,
    output logic [15:0]             o_frame_count
);

    localparam logic [FB_ADDR_BITS-1:0] LAST_ADDR = FB_ADDR_BITS'(FB_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_RENDER,
        S_WAIT_VSYNC
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [TRI_CNT_BITS-1:0] r_tri_cnt;
    logic [FB_DATA_BITS-1:0] r_clear_color;
    logic [FB_ADDR_BITS-1:0] r_clear_addr;
    logic                    r_display_buf;
    logic [15:0]             r_frame_count;
    logic                    r_frame_dropped;
    logic                    r_wr_en;
    logic [FB_ADDR_BITS:0]   r_wr_addr;
    logic [FB_DATA_BITS-1:0] r_wr_data;

    logic                    w_latch;
    logic                    w_swap;
    logic                    w_drop;
    logic                    w_raster_start;
    logic                    w_wr_en;
    logic [FB_ADDR_BITS-1:0] w_wr_addr;
    logic [FB_DATA_BITS-1:0] w_wr_data;

    always_comb begin
        w_next_state   = r_state;
        w_latch        = 1'b0;
        w_swap         = 1'b0;
        w_drop         = 1'b0;
        w_raster_start = 1'b0;
        w_wr_en        = 1'b0;
        w_wr_addr      = '0;
        w_wr_data      = '0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_latch      = 1'b1;
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_clear_addr;
                w_wr_data = r_clear_color;
                w_drop    = i_vsync_pulse;
                if (r_clear_addr == LAST_ADDR) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_drop = i_vsync_pulse;
                if (r_tri_cnt == '0) begin
                    w_next_state = S_WAIT_VSYNC;
                end else begin
                    w_raster_start = 1'b1;
                    w_next_state   = S_RENDER;
                end
            end
            S_RENDER: begin
                w_wr_en   = i_raster_wr_en;
                w_wr_addr = i_raster_wr_addr;
                w_wr_data = i_raster_wr_data;
                if (i_raster_done) begin
                    // done and vsync together still make the deadline
                    if (i_vsync_pulse) begin
                        w_swap       = 1'b1;
                        w_latch      = i_enable;
                        w_next_state = i_enable ? S_CLEAR : S_IDLE;
                    end else begin
                        w_next_state = S_WAIT_VSYNC;
                    end
                end else begin
                    w_drop = i_vsync_pulse;
                end
            end
            S_WAIT_VSYNC: begin
                if (i_vsync_pulse) begin
                    w_swap       = 1'b1;
                    w_latch      = i_enable;
                    w_next_state = i_enable ? S_CLEAR : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tri_cnt       <= '0;
            r_clear_color   <= '0;
            r_clear_addr    <= '0;
            r_display_buf   <= 1'b0;
            r_frame_count   <= '0;
            r_frame_dropped <= 1'b0;
            r_wr_en         <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
        end else begin
            r_frame_dropped <= w_drop;
            r_wr_en         <= w_wr_en;
            r_wr_addr       <= {~r_display_buf, w_wr_addr};
            r_wr_data       <= w_wr_data;
            if (w_latch) begin
                r_tri_cnt     <= i_tri_count;
                r_clear_color <= i_clear_color;
                r_clear_addr  <= '0;
            end else if (r_state == S_CLEAR && r_clear_addr != LAST_ADDR) begin
                r_clear_addr <= r_clear_addr + 1'b1;
            end
            if (w_swap) begin
                r_display_buf <= ~r_display_buf;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign o_raster_start   = w_raster_start;
    assign o_raster_tri_cnt = r_tri_cnt;
    assign o_fb_wr_en       = r_wr_en;
    assign o_fb_wr_addr     = r_wr_addr;
    assign o_fb_wr_data     = r_wr_data;
    assign o_display_buf    = r_display_buf;
    assign o_frame_count    = r_frame_count;
    assign o_frame_dropped  = r_frame_dropped;
    assign o_busy           = (r_state == S_CLEAR) || (r_state == S_START) || (r_state == S_RENDER);

endmodule
